attack_sequencer: RTL and testbench

- Per-player attack front end; one instance per fighter.
- Turns light/heavy button presses into timed attack phases: startup, active, recovery and hit-stun.
- Emits the `attack_state` damage code consumed by the health-management stage: exactly one clk cycle per landed strike, so the downstream per-clk decrement fires once per attack.
- Also drives pose/phase outputs for the sprite renderer.

---
 rtl/attack_sequencer.sv | 169 ++++++++++++++++
 tb/tb_attack_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_sequencer.sv
// Per-player attack sequencer: converts button presses into timed startup/active/recovery
// phases, handles hit-stun, and emits a one-cycle damage strobe per landed strike.
module attack_sequencer #(
  parameter int LIGHT_STARTUP  = 3,
  parameter int LIGHT_ACTIVE   = 2,
  parameter int LIGHT_RECOVERY = 6,
  parameter int HEAVY_STARTUP  = 6,
  parameter int HEAVY_ACTIVE   = 3,
  parameter int HEAVY_RECOVERY = 12,
  parameter int HITSTUN        = 10,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_light,
  input  logic       btn_heavy,
  input  logic       in_range,
  input  logic       hit_taken,
  input  logic [2:0] game_state,
  output logic [1:0] attack_state,
  output logic [2:0] phase,
  output logic       is_heavy,
  output logic       busy
);

  // state     | meaning
  // S_IDLE    | no attack, waiting for a press or buffered press
  // S_STARTUP | wind-up before the hit window
  // S_ACTIVE  | hit window, at most one strike
  // S_RECOVERY| cool-down, presses are buffered
  // S_STUN    | hit-stun after taking damage
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_RECOVERY = 3'd3,
    S_STUN     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_m1;
  logic             is_heavy_q, is_heavy_d;
  logic             buf_valid_q, buf_valid_d;
  logic             buf_heavy_q, buf_heavy_d;
  logic             strike_done_q, strike_done_d;
  logic [1:0]       attack_q, attack_d;
  logic             busy_q, busy_d;
  logic             prev_light_q, prev_heavy_q;
  logic             light_edge, heavy_edge, press;

  assign light_edge = btn_light & ~prev_light_q;
  assign heavy_edge = btn_heavy & ~prev_heavy_q;
  assign press      = light_edge | heavy_edge;

  always_comb begin
    len_m1 = '0;
    case (state_q)
      S_STARTUP:  len_m1 = is_heavy_q ? CNT_W'(HEAVY_STARTUP - 1)  : CNT_W'(LIGHT_STARTUP - 1);
      S_ACTIVE:   len_m1 = is_heavy_q ? CNT_W'(HEAVY_ACTIVE - 1)   : CNT_W'(LIGHT_ACTIVE - 1);
      S_RECOVERY: len_m1 = is_heavy_q ? CNT_W'(HEAVY_RECOVERY - 1) : CNT_W'(LIGHT_RECOVERY - 1);
      S_STUN:     len_m1 = CNT_W'(HITSTUN - 1);
      default:    len_m1 = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_heavy_d    = is_heavy_q;
    buf_valid_d   = buf_valid_q;
    buf_heavy_d   = buf_heavy_q;
    strike_done_d = strike_done_q;
    attack_d      = 2'b00;

    if (game_state != 3'b000) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      is_heavy_d    = 1'b0;
      buf_valid_d   = 1'b0;
      buf_heavy_d   = 1'b0;
      strike_done_d = 1'b0;
    end else if (hit_taken) begin
      state_d     = S_STUN;
      cnt_d       = '0;
      buf_valid_d = 1'b0;
      buf_heavy_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A buffered press beats a fresh edge; a same-clk frame_tick is not counted.
          if (buf_valid_q) begin
            state_d     = S_STARTUP;
            cnt_d       = '0;
            is_heavy_d  = buf_heavy_q;
            buf_valid_d = 1'b0;
            buf_heavy_d = 1'b0;
          end else if (press) begin
            state_d    = S_STARTUP;
            cnt_d      = '0;
            is_heavy_d = heavy_edge;
          end
        end
        S_STARTUP, S_ACTIVE, S_RECOVERY, S_STUN: begin
          if (frame_tick) begin
            if (cnt_q == len_m1) begin
              cnt_d = '0;
              case (state_q)
                S_STARTUP: state_d = S_ACTIVE;
                S_ACTIVE:  state_d = S_RECOVERY;
                default:   state_d = S_IDLE;
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (state_q == S_ACTIVE && in_range && !strike_done_q) begin
            attack_d      = is_heavy_q ? 2'b10 : 2'b01;
            strike_done_d = 1'b1;
          end
          if (state_q == S_RECOVERY && press) begin
            buf_valid_d = 1'b1;
            buf_heavy_d = heavy_edge | (buf_valid_q & buf_heavy_q);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (state_d == S_ACTIVE && state_q != S_ACTIVE) strike_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_heavy_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_heavy_q   <= 1'b0;
      strike_done_q <= 1'b0;
      attack_q      <= 2'b00;
      busy_q        <= 1'b0;
      prev_light_q  <= 1'b0;
      prev_heavy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_heavy_q    <= is_heavy_d;
      buf_valid_q   <= buf_valid_d;
      buf_heavy_q   <= buf_heavy_d;
      strike_done_q <= strike_done_d;
      attack_q      <= attack_d;
      busy_q        <= busy_d;
      prev_light_q  <= btn_light;
      prev_heavy_q  <= btn_heavy;
    end
  end

  assign attack_state = attack_q;
  assign phase        = state_q;
  assign is_heavy     = is_heavy_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Scoreboard bench for attack_sequencer: directed scenarios queue expected output events,
// a monitor pops one per observed output change and checks values, tick and clk spacing.
module tb_attack_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_light = 1'b0;
  logic       btn_heavy = 1'b0;
  logic       in_range = 1'b0;
  logic       hit_taken = 1'b0;
  logic [2:0] game_state = 3'b000;
  logic [1:0] attack_state;
  logic [2:0] phase;
  logic       is_heavy;
  logic       busy;

  attack_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_light(btn_light), .btn_heavy(btn_heavy), .in_range(in_range),
    .hit_taken(hit_taken), .game_state(game_state),
    .attack_state(attack_state), .phase(phase), .is_heavy(is_heavy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic [1:0] atk;
    logic       hv;
    int         ticks;  // frame_ticks spent in the phase just left, -1 = don't care
    int         clks;   // clks since the previous event, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic mon_en = 1'b0;
  logic tick_en = 1'b0;

  // frame_tick: one clk high every 4 clks
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk); #1;
      frame_tick = tick_en && (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    logic [2:0] p_ph;
    logic [1:0] p_atk;
    logic       p_hv, p_busy, ph_chg, ok;
    int         ticks, clks;
    ev_t        e;
    p_ph = 3'd0; p_atk = 2'd0; p_hv = 1'b0; p_busy = 1'b0;
    ticks = 0; clks = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      clks++;
      if ({phase, attack_state, is_heavy, busy} !== {p_ph, p_atk, p_hv, p_busy}) begin
        ph_chg = (phase !== p_ph);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got phase=%0d atk=%0d heavy=%0b busy=%0b, required no change (t=%0t)",
                   phase, attack_state, is_heavy, busy, $time);
        end else begin
          e = exp_q.pop_front();
          ok = (phase === e.ph) && (attack_state === e.atk) && (is_heavy === e.hv) &&
               (busy === (e.ph != 3'd0)) &&
               (e.ticks < 0 || (ph_chg && ticks == e.ticks)) &&
               (e.clks < 0 || clks == e.clks);
          if (!ok) begin
            n_bad++;
            $display("FAIL event: got phase=%0d atk=%0d heavy=%0b busy=%0b ticks=%0d clks=%0d, required phase=%0d atk=%0d heavy=%0b ticks=%0d clks=%0d (t=%0t)",
                     phase, attack_state, is_heavy, busy, ticks, clks,
                     e.ph, e.atk, e.hv, e.ticks, e.clks, $time);
          end
        end
        if (ph_chg) ticks = 0;
        clks = 0;
        p_ph = phase; p_atk = attack_state; p_hv = is_heavy; p_busy = busy;
      end
      ticks += int'(frame_tick);
    end
  end

  task automatic push(input logic [2:0] ph, input logic [1:0] atk, input logic hv,
                      input int ticks, input int clks);
    ev_t e;
    e.ph = ph; e.atk = atk; e.hv = hv; e.ticks = ticks; e.clks = clks;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at a negedge where phase == p, or reports a timeout.
  task automatic wait_phase(input logic [2:0] p, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (phase !== p && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (phase !== p) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got phase=%0d, required phase=%0d", name, phase, p);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    step(8);
  endtask

  task automatic press(input logic l, input logic h, input string name);
    step(1);
    btn_light = l;
    btn_heavy = h;
    wait_phase(3'd1, name);
    btn_light = 1'b0;
    btn_heavy = 1'b0;
  endtask

  initial begin
    int n;
    step(3);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({attack_state, phase, is_heavy, busy} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_state: got atk=%0d phase=%0d heavy=%0b busy=%0b, required all 0",
               attack_state, phase, is_heavy, busy);
    end
    mon_en = 1'b1;
    tick_en = 1'b1;
    step(4);

    // 1: light attack, in range throughout
    in_range = 1'b1;
    push(3'd1, 2'd0, 1'b0, -1, -1);
    push(3'd2, 2'd0, 1'b0, 3, -1);
    push(3'd2, 2'd1, 1'b0, -1, 1);
    push(3'd2, 2'd0, 1'b0, -1, 1);
    push(3'd3, 2'd0, 1'b0, 2, -1);
    push(3'd0, 2'd0, 1'b0, 6, -1);
    press(1'b1, 1'b0, "t1");
    drain("t1");
    in_range = 1'b0;

    // 2: simultaneous edges, heavy wins, out of range
    push(3'd1, 2'd0, 1'b1, -1, -1);
    push(3'd2, 2'd0, 1'b1, 6, -1);
    push(3'd3, 2'd0, 1'b1, 3, -1);
    push(3'd0, 2'd0, 1'b1, 12, -1);
    press(1'b1, 1'b1, "t2");
    drain("t2");

    // 3: heavy, in_range rises mid-ACTIVE and stays high
    push(3'd1, 2'd0, 1'b1, -1, -1);
    push(3'd2, 2'd0, 1'b1, 6, -1);
    push(3'd2, 2'd2, 1'b1, -1, -1);
    push(3'd2, 2'd0, 1'b1, -1, 1);
    push(3'd3, 2'd0, 1'b1, 3, -1);
    push(3'd0, 2'd0, 1'b1, 12, -1);
    press(1'b0, 1'b1, "t3");
    wait_phase(3'd2, "t3a");
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    step(1);
    in_range = 1'b1;
    drain("t3");
    in_range = 1'b0;

    // 4: press buffered in RECOVERY, press in STARTUP ignored
    push(3'd1, 2'd0, 1'b0, -1, -1);
    push(3'd2, 2'd0, 1'b0, 3, -1);
    push(3'd3, 2'd0, 1'b0, 2, -1);
    push(3'd0, 2'd0, 1'b0, 6, -1);
    push(3'd1, 2'd0, 1'b0, -1, 1);
    push(3'd2, 2'd0, 1'b0, 3, -1);
    push(3'd3, 2'd0, 1'b0, 2, -1);
    push(3'd0, 2'd0, 1'b0, 6, -1);
    press(1'b1, 1'b0, "t4");
    wait_phase(3'd3, "t4a");
    btn_light = 1'b1;
    step(2);
    btn_light = 1'b0;
    wait_phase(3'd1, "t4b");
    btn_heavy = 1'b1;
    step(2);
    btn_heavy = 1'b0;
    drain("t4");

    // 5: hit with strike condition, re-hit after 5 stun ticks
    push(3'd1, 2'd0, 1'b0, -1, -1);
    push(3'd2, 2'd0, 1'b0, 3, -1);
    push(3'd4, 2'd0, 1'b0, -1, -1);
    push(3'd0, 2'd0, 1'b0, 15, -1);
    press(1'b1, 1'b0, "t5");
    wait_phase(3'd2, "t5a");
    in_range = 1'b1;
    hit_taken = 1'b1;
    step(1);
    hit_taken = 1'b0;
    wait_phase(3'd4, "t5b");
    n = int'(frame_tick);
    while (n < 5 && phase === 3'd4) begin
      @(negedge clk);
      n += int'(frame_tick);
    end
    step(1);
    hit_taken = 1'b1;
    step(1);
    hit_taken = 1'b0;
    drain("t5");
    in_range = 1'b0;

    // 6: freeze mid-ACTIVE, held button across resume, then reset mid-STARTUP
    push(3'd1, 2'd0, 1'b0, -1, -1);
    push(3'd2, 2'd0, 1'b0, 3, -1);
    push(3'd0, 2'd0, 1'b0, -1, 1);
    press(1'b1, 1'b0, "t6");
    wait_phase(3'd2, "t6a");
    game_state = 3'b001;
    step(3);
    btn_light = 1'b1;
    step(10);
    game_state = 3'b000;
    step(40);
    btn_light = 1'b0;
    drain("t6");

    push(3'd1, 2'd0, 1'b0, -1, -1);
    push(3'd0, 2'd0, 1'b0, -1, 1);
    press(1'b1, 1'b0, "t6r");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({attack_state, phase, is_heavy, busy} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_mid_startup: got atk=%0d phase=%0d heavy=%0b busy=%0b, required all 0",
               attack_state, phase, is_heavy, busy);
    end
    drain("t6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
